ir_nec_decoder: RTL and testbench

- Consumes the demodulated IR envelope (idle high; low = carrier burst, "mark") from the IR receive front end.
- Decodes NEC-format frames into a 16-bit address and an 8-bit command.
- Flags repeat codes and malformed frames with single-cycle pulses to the control logic.
- Runs on the 25 MHz system clock and measures all durations in 10 us ticks.

---
 rtl/ir_nec_if.sv | 23 ++
 rtl/ir_nec_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_if.sv
// Signal bundle between the NEC IR decoder and its consumer: the demodulated
// envelope going in, the decoded frame fields and event pulses coming out.
interface ir_nec_if;
  logic        ir_env_i;
  logic [15:0] ir_addr;
  logic [7:0]  ir_cmd;
  logic        ir_valid;
  logic        ir_repeat;
  logic        ir_err;
  logic        ir_busy;

  // Decoder side
  modport master (
    input  ir_env_i,
    output ir_addr, ir_cmd, ir_valid, ir_repeat, ir_err, ir_busy
  );

  // Front end / control-logic side
  modport slave (
    output ir_env_i,
    input  ir_addr, ir_cmd, ir_valid, ir_repeat, ir_err, ir_busy
  );
endinterface

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder. Measures mark/space durations of the synchronized
// envelope in 10 us ticks and walks a leader/bit/check state machine that
// yields a 16-bit address, an 8-bit command and valid/repeat/error pulses.
module ir_nec_decoder #(
  parameter int CLK_DIV    = 250,
  parameter int LM_MIN     = 800,
  parameter int LM_MAX     = 1000,
  parameter int LS_MIN     = 350,
  parameter int LS_MAX     = 500,
  parameter int RS_MIN     = 150,
  parameter int RS_MAX     = 260,
  parameter int BM_MIN     = 40,
  parameter int BM_MAX     = 90,
  parameter int B0_MIN     = 20,
  parameter int B1_MIN     = 100,
  parameter int B1_MAX     = 220,
  parameter bit ADDR_CHECK = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  ir_nec_if.master bus
);

  localparam int               PSC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_DIV - 1);

  // Window bounds narrowed to the duration counter width
  localparam logic [11:0] LM_LO = 12'(LM_MIN);
  localparam logic [11:0] LM_HI = 12'(LM_MAX);
  localparam logic [11:0] LS_LO = 12'(LS_MIN);
  localparam logic [11:0] LS_HI = 12'(LS_MAX);
  localparam logic [11:0] RS_LO = 12'(RS_MIN);
  localparam logic [11:0] RS_HI = 12'(RS_MAX);
  localparam logic [11:0] BM_LO = 12'(BM_MIN);
  localparam logic [11:0] BM_HI = 12'(BM_MAX);
  localparam logic [11:0] B0_LO = 12'(B0_MIN);
  localparam logic [11:0] B0_HI = 12'(B1_MIN - 1);
  localparam logic [11:0] B1_LO = 12'(B1_MIN);
  localparam logic [11:0] B1_HI = 12'(B1_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK,
    S_BIT_SPACE, S_CHECK, S_REP_MARK, S_WAIT_HIGH
  } state_t;

  function automatic logic in_win(input logic [11:0] d, input logic [11:0] lo,
                                  input logic [11:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  logic             meta_q, sync_q, prev_q;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [11:0]      dur_q, dur_d;
  state_t           state_q, state_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shreg_q, shreg_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             valid_q, valid_d, repeat_q, repeat_d, err_q, err_d;
  logic             last_ok_q, last_ok_d;
  logic             fall_w, rise_w, edge_w, frame_ok_w;

  // Two-stage synchronizer plus a delayed copy for edge detection; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= bus.ir_env_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_w = prev_q & ~sync_q;
  assign rise_w = ~prev_q & sync_q;
  assign edge_w = fall_w | rise_w;

  assign frame_ok_w = (shreg_q[23:16] == ~shreg_q[31:24]) &&
                      (!ADDR_CHECK || (shreg_q[15:8] == ~shreg_q[7:0]));

  // Tick prescaler and saturating duration counter, both restarted on every edge
  always_comb begin
    psc_d = psc_q;
    dur_d = dur_q;
    if (edge_w) begin
      psc_d = '0;
      dur_d = '0;
    end else if (psc_q == PSC_LAST) begin
      psc_d = '0;
      if (dur_q != 12'hFFF) dur_d = dur_q + 12'd1;
    end else begin
      psc_d = psc_q + 1'b1;
    end
  end

  // Frame state machine: every duration is judged at the edge that ends it
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    last_ok_d = last_ok_q;
    valid_d   = 1'b0;
    repeat_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: if (fall_w) state_d = S_LEAD_MARK;
      S_LEAD_MARK: begin
        if (rise_w) begin
          if (in_win(dur_q, LM_LO, LM_HI)) state_d = S_LEAD_SPACE;
          else if (dur_q < LM_LO)          state_d = S_IDLE;
          else begin err_d = 1'b1; state_d = S_IDLE; end
        end else if (dur_q > LM_HI) begin
          err_d = 1'b1; state_d = S_WAIT_HIGH;
        end
      end
      S_LEAD_SPACE: begin
        if (fall_w) begin
          if (in_win(dur_q, LS_LO, LS_HI)) begin
            state_d   = S_BIT_MARK;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else if (in_win(dur_q, RS_LO, RS_HI)) begin
            state_d = S_REP_MARK;
          end else begin
            err_d = 1'b1; state_d = S_LEAD_MARK;
          end
        end else if (rise_w || dur_q > LS_HI) begin
          err_d = 1'b1; state_d = S_IDLE;
        end
      end
      S_BIT_MARK: begin
        if (edge_w) begin
          if (rise_w && in_win(dur_q, BM_LO, BM_HI)) state_d = S_BIT_SPACE;
          else begin err_d = 1'b1; state_d = S_IDLE; end
        end else if (dur_q > BM_HI) begin
          err_d = 1'b1; state_d = S_WAIT_HIGH;
        end
      end
      S_BIT_SPACE: begin
        if (fall_w && (in_win(dur_q, B0_LO, B0_HI) || in_win(dur_q, B1_LO, B1_HI))) begin
          shreg_d   = {in_win(dur_q, B1_LO, B1_HI), shreg_q[31:1]};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd31) ? S_CHECK : S_BIT_MARK;
        end else if (edge_w || dur_q > B1_HI) begin
          err_d = 1'b1; state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (frame_ok_w) begin
          addr_d    = shreg_q[15:0];
          cmd_d     = shreg_q[23:16];
          valid_d   = 1'b1;
          last_ok_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_WAIT_HIGH;
      end
      S_REP_MARK: begin
        if (edge_w) begin
          if (rise_w && in_win(dur_q, BM_LO, BM_HI) && last_ok_q) repeat_d = 1'b1;
          else err_d = 1'b1;
          state_d = S_IDLE;
        end else if (dur_q > BM_HI) begin
          err_d = 1'b1; state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (sync_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (err_d) last_ok_d = 1'b0;
  end

  // Register timing, FSM state, decoded fields and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q     <= '0;
      dur_q     <= '0;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      addr_q    <= '0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      err_q     <= 1'b0;
      last_ok_q <= 1'b0;
    end else begin
      psc_q     <= psc_d;
      dur_q     <= dur_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      repeat_q  <= repeat_d;
      err_q     <= err_d;
      last_ok_q <= last_ok_d;
    end
  end

  assign bus.ir_addr   = addr_q;
  assign bus.ir_cmd    = cmd_q;
  assign bus.ir_valid  = valid_q;
  assign bus.ir_repeat = repeat_q;
  assign bus.ir_err    = err_q;
  assign bus.ir_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder. Runs the prescaler at one clock per
// tick so whole NEC frames fit in a short run; all durations are in ticks.
module tb_ir_nec_decoder;
  localparam int CLK_DIV = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_valid = 0, n_rep = 0, n_err = 0, n_multi = 0;
  int   err_cyc = 0;

  ir_nec_if bus();

  ir_nec_decoder #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  // Free-running cycle count for timing measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Count every cycle each pulse is high, away from the active edge
  always @(negedge clk) begin
    if (bus.ir_valid)  n_valid <= n_valid + 1;
    if (bus.ir_repeat) n_rep   <= n_rep + 1;
    if (bus.ir_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if ($countones({bus.ir_valid, bus.ir_repeat, bus.ir_err}) > 1) n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic hold(input logic lvl, input int ticks);
    bus.ir_env_i = lvl;
    repeat (ticks * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, 72);
      hold(1'b1, w[i] ? 153 : 40);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] c, input logic [7:0] cn);
    hold(1'b0, 916);
    hold(1'b1, 434);
    send_bits({cn, c, b1, b0}, 32);
    hold(1'b0, 72);
    hold(1'b1, 200);
  endtask

  task automatic send_repeat();
    hold(1'b0, 900);
    hold(1'b1, 209);
    hold(1'b0, 72);
    hold(1'b1, 200);
  endtask

  initial begin
    int v0, r0, e0, t0, d;
    bus.ir_env_i = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_addr",   32'(bus.ir_addr),   32'h0);
    check("rst_cmd",    32'(bus.ir_cmd),    32'h0);
    check("rst_valid",  32'(bus.ir_valid),  32'h0);
    check("rst_repeat", 32'(bus.ir_repeat), 32'h0);
    check("rst_err",    32'(bus.ir_err),    32'h0);
    check("rst_busy",   32'(bus.ir_busy),   32'h0);
    rst_n = 1'b1;
    hold(1'b1, 20);

    // Repeat code with no good frame behind it
    send_repeat();
    check("rep_after_rst_err", 32'(n_err), 32'd1);
    check("rep_after_rst_rep", 32'(n_rep), 32'd0);

    // Good frame
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
    check("f1_valid", 32'(n_valid), 32'd1);
    check("f1_err",   32'(n_err),   32'd1);
    check("f1_addr",  32'(bus.ir_addr), 32'h0000FF00);
    check("f1_cmd",   32'(bus.ir_cmd),  32'h45);
    check("f1_busy",  32'(bus.ir_busy), 32'h0);

    // Repeat code after the good frame
    hold(1'b1, 400);
    send_repeat();
    check("rep_pulse", 32'(n_rep),       32'd1);
    check("rep_addr",  32'(bus.ir_addr), 32'h0000FF00);
    check("rep_cmd",   32'(bus.ir_cmd),  32'h45);

    // Frame with bad command complement, then a repeat
    v0 = n_valid; e0 = n_err; r0 = n_rep;
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBB);
    check("bad_err",   32'(n_err - e0),   32'd1);
    check("bad_valid", 32'(n_valid - v0), 32'd0);
    check("bad_cmd",   32'(bus.ir_cmd),   32'h45);
    check("bad_addr",  32'(bus.ir_addr),  32'h0000FF00);
    send_repeat();
    check("bad_rep_err", 32'(n_err - e0), 32'd2);
    check("bad_rep_rep", 32'(n_rep - r0), 32'd0);

    // Short mark is treated as noise
    v0 = n_valid; e0 = n_err; r0 = n_rep;
    hold(1'b0, 500);
    hold(1'b1, 200);
    check("noise_err",   32'(n_err - e0),   32'd0);
    check("noise_valid", 32'(n_valid - v0), 32'd0);
    check("noise_rep",   32'(n_rep - r0),   32'd0);
    check("noise_busy",  32'(bus.ir_busy),  32'h0);

    // Overlong leader mark times out once dur passes the window
    t0 = cyc;
    hold(1'b0, 1200);
    hold(1'b1, 200);
    d = err_cyc - t0;
    check("long_err", 32'(n_err - e0), 32'd1);
    check("long_err_time_ok", 32'(d >= 1000 && d <= 1010), 32'd1);
    check("long_busy", 32'(bus.ir_busy), 32'h0);

    // Envelope stuck high after 10 data bits
    e0 = n_err; v0 = n_valid;
    hold(1'b0, 916);
    hold(1'b1, 434);
    send_bits(32'hCB34ED12, 10);
    hold(1'b0, 72);
    t0 = cyc;
    hold(1'b1, 400);
    d = err_cyc - t0;
    check("stuck_err", 32'(n_err - e0), 32'd1);
    check("stuck_err_time_ok", 32'(d >= 220 && d <= 230), 32'd1);
    check("stuck_busy", 32'(bus.ir_busy), 32'h0);
    send_frame(8'h12, 8'hED, 8'h34, 8'hCB);
    check("f2_valid", 32'(n_valid - v0), 32'd1);
    check("f2_addr",  32'(bus.ir_addr),  32'h0000ED12);
    check("f2_cmd",   32'(bus.ir_cmd),   32'h34);

    // Reset in the middle of a frame
    v0 = n_valid; e0 = n_err; r0 = n_rep;
    hold(1'b0, 916);
    hold(1'b1, 434);
    send_bits(32'hF00FA55A, 20);
    bus.ir_env_i = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(bus.ir_addr),  32'h0);
    check("mid_rst_cmd",  32'(bus.ir_cmd),   32'h0);
    check("mid_rst_busy", 32'(bus.ir_busy),  32'h0);
    check("mid_rst_err",  32'(bus.ir_err),   32'h0);
    @(negedge clk);
    hold(1'b1, 20);
    rst_n = 1'b1;
    hold(1'b1, 50);
    check("mid_rst_no_pulse", 32'((n_valid - v0) + (n_err - e0) + (n_rep - r0)), 32'd0);
    send_frame(8'h5A, 8'hA5, 8'h0F, 8'hF0);
    check("f3_valid", 32'(n_valid - v0), 32'd1);
    check("f3_addr",  32'(bus.ir_addr),  32'h0000A55A);
    check("f3_cmd",   32'(bus.ir_cmd),   32'h0F);
    send_repeat();
    check("f3_rep", 32'(n_rep - r0), 32'd1);

    check("pulse_overlap", 32'(n_multi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
